// File: rtl/alu_muldiv.sv
// Integer ALU with an iterative shift-add multiplier and a restoring divider.
// One request is in flight at a time; results are held until the consumer accepts them.
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   op1,
  input  logic [WIDTH-1:0]   op2,
  input  logic [SHW-1:0]     shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               zero_flag,
  output logic               div_by_zero,
  output logic               illegal_op,
  output logic               busy
);

  localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND   = 4'd2,  OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4,  OP_NOR  = 4'd5,  OP_SLL   = 4'd6,  OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8,  OP_SLT  = 4'd9,  OP_SLTU  = 4'd10, OP_MULT = 4'd11;
  localparam logic [3:0] OP_MULTU = 4'd12, OP_DIV = 4'd13, OP_DIVU  = 4'd14, OP_RSVD = 4'd15;
  localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t               state_q;
  logic [SHW-1:0]       cnt_q;
  logic [WIDTH-1:0]     hi_q, lo_q, a_q, op1_q;
  logic                 neg_lo_q, neg_hi_q, div0_q;
  logic                 out_valid_q, zero_q, dbz_q, ill_q;
  logic [2*WIDTH-1:0]   result_q;

  logic                 accept;
  logic                 is_signed;
  logic [WIDTH-1:0]     abs1, abs2, alu_lo;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next, mul_final;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH+1:0]     div_diff;
  logic                 div_ok;
  logic [WIDTH-1:0]     rem_next, quo_next, div_hi_final, div_lo_final;

  assign in_ready    = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept      = in_valid && in_ready && !flush;
  assign busy        = (state_q == S_MUL) || (state_q == S_DIV);
  assign out_valid   = out_valid_q;
  assign result      = result_q;
  assign zero_flag   = zero_q;
  assign div_by_zero = dbz_q;
  assign illegal_op  = ill_q;

  always_comb begin
    alu_lo = '0;
    case (op)
      OP_ADD:  alu_lo = op1 + op2;
      OP_SUB:  alu_lo = op1 - op2;
      OP_AND:  alu_lo = op1 & op2;
      OP_OR:   alu_lo = op1 | op2;
      OP_XOR:  alu_lo = op1 ^ op2;
      OP_NOR:  alu_lo = ~(op1 | op2);
      OP_SLL:  alu_lo = op2 << shamt;
      OP_SRL:  alu_lo = op2 >> shamt;
      OP_SRA:  alu_lo = $signed(op2) >>> shamt;
      OP_SLT:  alu_lo = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
      OP_SLTU: alu_lo = {{(WIDTH-1){1'b0}}, (op1 < op2)};
      default: alu_lo = '0;
    endcase
  end

  // Signed ops run on magnitudes; the sign is re-applied on the last iteration.
  always_comb begin
    is_signed = (op == OP_MULT) || (op == OP_DIV);
    abs1 = (is_signed && op1[WIDTH-1]) ? -op1 : op1;
    abs2 = (is_signed && op2[WIDTH-1]) ? -op2 : op2;
  end

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    mul_next  = {mul_sum, lo_q[WIDTH-1:1]};
    mul_final = neg_lo_q ? -mul_next : mul_next;
  end

  always_comb begin
    div_shift    = {hi_q, lo_q[WIDTH-1]};
    div_diff     = {1'b0, div_shift} - {2'b00, a_q};
    div_ok       = !div_diff[WIDTH+1];
    rem_next     = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    quo_next     = {lo_q[WIDTH-2:0], div_ok};
    div_hi_final = div0_q ? op1_q : (neg_hi_q ? -rem_next : rem_next);
    div_lo_final = div0_q ? {WIDTH{1'b1}} : (neg_lo_q ? -quo_next : quo_next);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      a_q         <= '0;
      op1_q       <= '0;
      neg_lo_q    <= 1'b0;
      neg_hi_q    <= 1'b0;
      div0_q      <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      dbz_q       <= 1'b0;
      ill_q       <= 1'b0;
    end else if (flush) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      cnt_q <= '0;
      hi_q  <= '0;
      op1_q <= op1;
      case (op)
        OP_MULT, OP_MULTU: begin
          state_q     <= S_MUL;
          out_valid_q <= 1'b0;
          a_q         <= abs1;
          lo_q        <= abs2;
          neg_lo_q    <= is_signed && (op1[WIDTH-1] ^ op2[WIDTH-1]);
          neg_hi_q    <= 1'b0;
          div0_q      <= 1'b0;
        end
        OP_DIV, OP_DIVU: begin
          state_q     <= S_DIV;
          out_valid_q <= 1'b0;
          a_q         <= abs2;
          lo_q        <= abs1;
          neg_lo_q    <= is_signed && (op1[WIDTH-1] ^ op2[WIDTH-1]);
          neg_hi_q    <= is_signed && op1[WIDTH-1];
          div0_q      <= (op2 == '0);
        end
        default: begin
          state_q     <= S_DONE;
          out_valid_q <= 1'b1;
          result_q    <= {{WIDTH{1'b0}}, alu_lo};
          zero_q      <= (alu_lo == '0);
          dbz_q       <= 1'b0;
          ill_q       <= (op == OP_RSVD);
        end
      endcase
    end else begin
      case (state_q)
        S_MUL: begin
          if (cnt_q == LAST_ITER) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            result_q    <= mul_final;
            zero_q      <= (mul_final[WIDTH-1:0] == '0);
            dbz_q       <= 1'b0;
            ill_q       <= 1'b0;
          end else begin
            {hi_q, lo_q} <= mul_next;
            cnt_q        <= cnt_q + 1'b1;
          end
        end
        S_DIV: begin
          if (cnt_q == LAST_ITER) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            result_q    <= {div_hi_final, div_lo_final};
            zero_q      <= (div_lo_final == '0);
            dbz_q       <= div0_q;
            ill_q       <= 1'b0;
          end else begin
            hi_q  <= rem_next;
            lo_q  <= quo_next;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv: hand-computed vectors, latency, backpressure, reset and flush.
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        in_ready, out_valid, zero_flag, div_by_zero, illegal_op, busy;
  logic [3:0]  op;
  logic [31:0] op1, op2;
  logic [4:0]  shamt;
  logic [63:0] result;

  int nvec = 0;
  int nerr = 0;
  int lat;
  logic seen;

  alu_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .op1(op1), .op2(op2), .shamt(shamt), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero_flag(zero_flag), .div_by_zero(div_by_zero),
    .illegal_op(illegal_op), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-14s observed %h expected %h", tag, obs, exp);
  endtask

  // Issue one op; the accepting edge has passed on return.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] s);
    op = o; op1 = a; op2 = b; shamt = s; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Issue a multi-cycle op, scramble the inputs, and count edges until out_valid.
  task automatic run_multi(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                           output int n);
    issue(o, a, b, 5'd0);
    op1 = $urandom; op2 = $urandom; op = 4'd0;
    n = 1;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; op1 = '0; op2 = '0; shamt = '0;
    tick(); tick();
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_flags", {61'd0, zero_flag, div_by_zero, illegal_op}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    reset = 1'b1;
    tick();

    issue(4'd0, 32'd5, 32'd7, 5'd0);
    chk("add_valid", {63'd0, out_valid}, 64'd1);
    chk("add_result", result, 64'd12);
    chk("add_zero", {63'd0, zero_flag}, 64'd0);
    issue(4'd1, 32'd7, 32'd7, 5'd0);
    chk("sub_result", result, 64'd0);
    chk("sub_zero", {63'd0, zero_flag}, 64'd1);
    tick();
    chk("idle_valid", {63'd0, out_valid}, 64'd0);

    issue(4'd2, 32'h0000F0F0, 32'h0000FF00, 5'd0);
    chk("and", result, 64'h0000_F000);
    issue(4'd3, 32'h0000F0F0, 32'h0000FF00, 5'd0);
    chk("or", result, 64'h0000_FFF0);
    issue(4'd4, 32'h0000F0F0, 32'h0000FF00, 5'd0);
    chk("xor", result, 64'h0000_0FF0);
    issue(4'd5, 32'd0, 32'd0, 5'd0);
    chk("nor", result, 64'h0000_0000_FFFF_FFFF);
    issue(4'd6, 32'hDEAD0000, 32'h00000001, 5'd31);
    chk("sll", result, 64'h0000_0000_8000_0000);
    issue(4'd7, 32'h0, 32'h80000000, 5'd4);
    chk("srl", result, 64'h0000_0000_0800_0000);
    issue(4'd9, 32'hFFFFFFFF, 32'd1, 5'd0);
    chk("slt", result, 64'd1);
    issue(4'd10, 32'hFFFFFFFF, 32'd1, 5'd0);
    chk("sltu", result, 64'd0);
    issue(4'd15, 32'd3, 32'd4, 5'd0);
    chk("rsvd_result", result, 64'd0);
    chk("rsvd_illegal", {63'd0, illegal_op}, 64'd1);

    issue(4'd11, 32'hFFFFFFFD, 32'd4, 5'd0);
    chk("mul_busy", {63'd0, busy}, 64'd1);
    chk("mul_in_ready", {63'd0, in_ready}, 64'd0);
    lat = 1;
    while (!out_valid && lat < 100) begin
      op1 = $urandom; op2 = $urandom;
      tick();
      lat++;
    end
    chk("mult_latency", 64'(lat), 64'd33);
    chk("mult", result, 64'hFFFF_FFFF_FFFF_FFF4);
    chk("mult_illegal", {63'd0, illegal_op}, 64'd0);

    run_multi(4'd12, 32'hFFFFFFFD, 32'd4, lat);
    chk("multu_latency", 64'(lat), 64'd33);
    chk("multu", result, 64'h0000_0003_FFFF_FFF4);

    run_multi(4'd13, 32'hFFFFFFF9, 32'd2, lat);
    chk("div_neg", result, 64'hFFFF_FFFF_FFFF_FFFD);
    run_multi(4'd13, 32'd7, 32'hFFFFFFFE, lat);
    chk("div_negdvsr", result, 64'h0000_0001_FFFF_FFFD);
    run_multi(4'd13, 32'h80000000, 32'hFFFFFFFF, lat);
    chk("div_minneg", result, 64'h0000_0000_8000_0000);
    chk("div_minneg_dbz", {63'd0, div_by_zero}, 64'd0);
    run_multi(4'd14, 32'd100, 32'd7, lat);
    chk("divu", result, 64'h0000_0002_0000_000E);
    run_multi(4'd14, 32'd10, 32'd0, lat);
    chk("divu0_latency", 64'(lat), 64'd33);
    chk("divu0", result, 64'h0000_000A_FFFF_FFFF);
    chk("divu0_dbz", {63'd0, div_by_zero}, 64'd1);
    chk("divu0_zero", {63'd0, zero_flag}, 64'd0);

    tick();
    out_ready = 1'b0;
    issue(4'd8, 32'h0, 32'h80000000, 5'd4);
    for (int i = 0; i < 5; i++) begin
      chk("sra_hold_valid", {63'd0, out_valid}, 64'd1);
      chk("sra_hold", result, 64'h0000_0000_F800_0000);
      chk("sra_in_ready", {63'd0, in_ready}, 64'd0);
      op1 = $urandom; op2 = $urandom; shamt = 5'($urandom);
      tick();
    end
    out_ready = 1'b1;
    #0;
    chk("b2b_in_ready", {63'd0, in_ready}, 64'd1);
    issue(4'd4, 32'h12345678, 32'hFFFF0000, 5'd0);
    chk("b2b_valid", {63'd0, out_valid}, 64'd1);
    chk("b2b_xor", result, 64'h0000_0000_EDCB_5678);

    issue(4'd13, 32'd1000, 32'd3, 5'd0);
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("rstdiv_valid", {63'd0, out_valid}, 64'd0);
    chk("rstdiv_busy", {63'd0, busy}, 64'd0);
    chk("rstdiv_in_ready", {63'd0, in_ready}, 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      seen = seen | out_valid;
    end
    chk("rstdiv_no_valid", {63'd0, seen}, 64'd0);

    flush = 1'b1;
    issue(4'd0, 32'd1, 32'd2, 5'd0);
    flush = 1'b0;
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    chk("flush_valid2", {63'd0, out_valid}, 64'd0);

    issue(4'd11, 32'd6, 32'd7, 5'd0);
    for (int i = 0; i < 5; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flushmul_busy", {63'd0, busy}, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      seen = seen | out_valid;
    end
    chk("flushmul_none", {63'd0, seen}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
